lpf_boxcar_mc: RTL and testbench

- Multi-channel, runtime-configurable moving-average (boxcar) low-pass filter.
- Successor to the fixed 8-tap single-channel LPF used on the audio/PSG mixing path.
- Supports 1..2^LOG2_MAXTAPS taps, selectable per frame. Uses a running-sum architecture with one shared adder, time-multiplexed across CHANNELS.
- Sits between the sound-source mixers and the DAC/I2S output stage, clocked by CLK21M and strobed at the sample rate.

---
 rtl/lpf_boxcar_mc.sv | 158 +++++++++++++++
 tb/tb_lpf_boxcar_mc.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lpf_boxcar_mc.sv
`default_nettype none
// ============================================================================
//  Module      : lpf_boxcar_mc
//  Description : Multi-channel moving-average (boxcar) low-pass filter with a
//                runtime-selectable power-of-two tap count. One running-sum
//                adder is time-multiplexed across all channels; results are
//                staged and committed together with a single OVALID pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module lpf_boxcar_mc #(
    parameter int WIDTH        = 16,
    parameter int CHANNELS     = 2,
    parameter int LOG2_MAXTAPS = 4
) (
    input  logic                      CLK21M,
    input  logic                      RESET,
    input  logic                      CLKENA,
    input  logic [CHANNELS*WIDTH-1:0] IDATA,
    input  logic [2:0]                TAPS_LOG2,
    output logic [CHANNELS*WIDTH-1:0] ODATA,
    output logic                      OVALID,
    output logic                      BUSY,
    output logic                      OVERRUN
);

    localparam int c_DEPTH = 1 << LOG2_MAXTAPS;
    localparam int c_SUMW  = WIDTH + LOG2_MAXTAPS;
    localparam int c_CHW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [2:0]       c_KMAX    = 3'(LOG2_MAXTAPS);
    localparam logic [c_CHW-1:0] c_LAST_CH = c_CHW'(CHANNELS - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]                r_state;
    logic [0:0]                w_state_next;
    logic [c_CHW-1:0]          r_ch;
    logic [2:0]                r_k;
    logic [2:0]                r_prev_k;
    logic                      r_flush;
    logic [CHANNELS*WIDTH-1:0] r_idata;
    logic [WIDTH-1:0]          r_delay [CHANNELS][c_DEPTH];
    logic [c_SUMW-1:0]         r_sum   [CHANNELS];
    logic [WIDTH-1:0]          r_stage [CHANNELS];

    logic                      w_accept;
    logic                      w_run;
    logic                      w_last;
    logic [2:0]                w_k_clamp;
    logic [LOG2_MAXTAPS-1:0]   w_tap_idx;
    logic [WIDTH-1:0]          w_new;
    logic [WIDTH-1:0]          w_oldest;
    logic [c_SUMW-1:0]         w_old_sum;
    logic [c_SUMW-1:0]         w_sum_next;
    logic [WIDTH-1:0]          w_result;
    logic [CHANNELS*WIDTH-1:0] w_commit;

    assign w_run     = (r_state == S_RUN);
    assign w_accept  = (r_state == S_IDLE) && CLKENA;
    assign w_last    = (r_ch == c_LAST_CH);
    assign w_k_clamp = (TAPS_LOG2 > c_KMAX) ? c_KMAX : TAPS_LOG2;
    // Index of the oldest sample inside the active window: 2^K - 1
    assign w_tap_idx = ~({LOG2_MAXTAPS{1'b1}} << r_k);

    // Shared running-sum datapath; a pending flush makes history read as zero
    assign w_new      = r_idata[r_ch*WIDTH +: WIDTH];
    assign w_oldest   = r_flush ? '0 : r_delay[r_ch][w_tap_idx];
    assign w_old_sum  = r_flush ? '0 : r_sum[r_ch];
    assign w_sum_next = w_old_sum + c_SUMW'(w_new) - c_SUMW'(w_oldest);
    assign w_result   = WIDTH'(w_sum_next >> r_k);

    // Assemble the committed word: staged results plus the channel finishing now
    always_comb begin
        w_commit = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            w_commit[ch*WIDTH +: WIDTH] = (ch == CHANNELS - 1) ? w_result : r_stage[ch];
        end
    end

    // State register
    always_ff @(posedge CLK21M or posedge RESET) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic: run one cycle per channel, then return to idle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (CLKENA) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        BUSY = (r_state == S_RUN);
    end

    // Frame control: latch inputs, step channel index, commit results, flag overruns
    always_ff @(posedge CLK21M or posedge RESET) begin
        if (RESET) begin
            r_ch     <= '0;
            r_k      <= '0;
            r_prev_k <= '0;
            r_flush  <= 1'b0;
            r_idata  <= '0;
            ODATA    <= '0;
            OVALID   <= 1'b0;
            OVERRUN  <= 1'b0;
        end else begin
            OVALID <= 1'b0;
            if (CLKENA && w_run) OVERRUN <= 1'b1;
            if (w_accept) begin
                r_idata  <= IDATA;
                r_k      <= w_k_clamp;
                r_prev_k <= w_k_clamp;
                r_flush  <= (w_k_clamp != r_prev_k);
                r_ch     <= '0;
            end else if (w_run) begin
                r_flush <= 1'b0;
                r_ch    <= r_ch + 1'b1;
                if (w_last) begin
                    ODATA  <= w_commit;
                    OVALID <= 1'b1;
                end
            end
        end
    end

    // Per-channel delay lines, running sums and result staging
    always_ff @(posedge CLK21M or posedge RESET) begin
        if (RESET) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                r_sum[ch]   <= '0;
                r_stage[ch] <= '0;
                for (int d = 0; d < c_DEPTH; d++) r_delay[ch][d] <= '0;
            end
        end else if (w_run) begin
            r_stage[r_ch] <= w_result;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (c_CHW'(ch) == r_ch) begin
                    r_sum[ch] <= w_sum_next;
                    for (int d = 0; d < c_DEPTH; d++) begin
                        if (d == 0) r_delay[ch][d] <= w_new;
                        else        r_delay[ch][d] <= r_flush ? '0 : r_delay[ch][d-1];
                    end
                end else if (r_flush) begin
                    r_sum[ch] <= '0;
                    for (int d = 0; d < c_DEPTH; d++) r_delay[ch][d] <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lpf_boxcar_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lpf_boxcar_mc
//  Description : Self-checking bench for lpf_boxcar_mc against a window-sum
//                reference model (directed plan items plus random frames).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lpf_boxcar_mc;

    localparam int W = 16;
    localparam int C = 2;
    localparam int L = 4;

    logic           CLK21M = 1'b0;
    logic           RESET  = 1'b1;
    logic           CLKENA = 1'b0;
    logic [C*W-1:0] IDATA  = '0;
    logic [2:0]     TAPS_LOG2 = '0;
    logic [C*W-1:0] ODATA;
    logic           OVALID;
    logic           BUSY;
    logic           OVERRUN;

    lpf_boxcar_mc #(.WIDTH(W), .CHANNELS(C), .LOG2_MAXTAPS(L)) dut (
        .CLK21M    (CLK21M),
        .RESET     (RESET),
        .CLKENA    (CLKENA),
        .IDATA     (IDATA),
        .TAPS_LOG2 (TAPS_LOG2),
        .ODATA     (ODATA),
        .OVALID    (OVALID),
        .BUSY      (BUSY),
        .OVERRUN   (OVERRUN)
    );

    always #5 CLK21M = ~CLK21M;

    int             total  = 0;
    int             passed = 0;
    int             failed = 0;
    int             hist [C][1<<L];
    int             m_prev_k = 0;
    logic [C*W-1:0] last_out = '0;
    logic           exp_ovr  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int ch = 0; ch < C; ch++)
            for (int i = 0; i < (1<<L); i++) hist[ch][i] = 0;
        m_prev_k = 0;
        last_out = '0;
    endtask

    // Output = floor(sum of the last 2^K accepted samples / 2^K); history
    // since the last tap-count change only, older slots count as zero.
    task automatic model_frame(input logic [C*W-1:0] d, input logic [2:0] k_in,
                               output logic [C*W-1:0] r);
        int    k;
        longint s;
        k = (int'(k_in) > L) ? L : int'(k_in);
        if (k != m_prev_k)
            for (int ch = 0; ch < C; ch++)
                for (int i = 0; i < (1<<L); i++) hist[ch][i] = 0;
        m_prev_k = k;
        r = '0;
        for (int ch = 0; ch < C; ch++) begin
            for (int i = (1<<L) - 1; i > 0; i--) hist[ch][i] = hist[ch][i-1];
            hist[ch][0] = int'(d[ch*W +: W]);
            s = 0;
            for (int i = 0; i < (1<<k); i++) s += hist[ch][i];
            r[ch*W +: W] = W'(s >> k);
        end
    endtask

    // One frame: strobe, check BUSY window, check the commit cycle
    task automatic send(input logic [C*W-1:0] d, input logic [2:0] k, input bit now);
        logic [C*W-1:0] e;
        model_frame(d, k, e);
        if (!now) @(negedge CLK21M);
        CLKENA = 1'b1; IDATA = d; TAPS_LOG2 = k;
        @(negedge CLK21M);
        CLKENA = 1'b0; IDATA = (C*W)'($urandom); TAPS_LOG2 = 3'($urandom);
        for (int c = 0; c < C; c++) begin
            if (c > 0) @(negedge CLK21M);
            chk("busy_during_frame", BUSY, 1);
            chk("ovalid_early", OVALID, 0);
        end
        @(negedge CLK21M);
        chk("ovalid_commit", OVALID, 1);
        chk("busy_commit", BUSY, 0);
        chk("odata_commit", ODATA, e);
        last_out = e;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK21M);
            chk("ovalid_idle", OVALID, 0);
            chk("busy_idle", BUSY, 0);
            chk("odata_hold", ODATA, last_out);
            chk("overrun_idle", OVERRUN, exp_ovr);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK21M);
        RESET = 1'b1; CLKENA = 1'b0;
        model_clear();
        exp_ovr = 1'b0;
        @(negedge CLK21M);
        RESET = 1'b0;
        chk("rst_odata", ODATA, 0);
        chk("rst_ovalid", OVALID, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_overrun", OVERRUN, 0);
    endtask

    initial begin
        logic [C*W-1:0] d;
        logic [2:0]     k;

        // Reset values and basic frame timing
        model_clear();
        repeat (2) @(negedge CLK21M);
        do_reset();
        idle(2);
        send({16'd0, 16'd0}, 3'd0, 1'b0);

        // Step response, K=3
        do_reset();
        for (int n = 1; n <= 10; n++) begin
            send({16'd0, 16'd800}, 3'd3, 1'b0);
            chk("step_ch0", ODATA[W-1:0], (n >= 8) ? 800 : 100 * n);
            chk("step_ch1", ODATA[2*W-1:W], 0);
            idle(6);
        end

        // Truncation and channel independence, K=3
        do_reset();
        for (int n = 1; n <= 8; n++) begin
            send({16'hFFFF, 16'd7}, 3'd3, 1'b0);
            chk("trunc_ch0", ODATA[W-1:0], n - 1);
            chk("trunc_ch1", ODATA[2*W-1:W], (65535 * n) >> 3);
        end

        // Bypass, then tap change with flush
        do_reset();
        send({16'd1234, 16'd5}, 3'd0, 1'b0);
        chk("bypass_5", ODATA[W-1:0], 5);
        chk("bypass_ch1", ODATA[2*W-1:W], 1234);
        send({16'd77, 16'd9}, 3'd0, 1'b1);
        chk("bypass_9", ODATA[W-1:0], 9);
        send({16'd12, 16'd12}, 3'd2, 1'b0);
        chk("flush_first", ODATA[W-1:0], 3);
        send({16'd12, 16'd12}, 3'd2, 1'b0);
        chk("flush_second", ODATA[W-1:0], 6);
        send({16'd40, 16'd40}, 3'd7, 1'b0);
        chk("clamp_first", ODATA[W-1:0], 40 >> 4);

        // Overrun: second strobe dropped, single OVALID, sticky flag
        do_reset();
        idle(1);
        d = {16'd300, 16'd600};
        model_frame(d, 3'd1, last_out);
        @(negedge CLK21M);
        CLKENA = 1'b1; IDATA = d; TAPS_LOG2 = 3'd1;
        @(negedge CLK21M);
        IDATA = {16'd999, 16'd999};
        chk("ovr_busy", BUSY, 1);
        chk("ovr_not_yet", OVERRUN, 0);
        @(negedge CLK21M);
        CLKENA = 1'b0;
        chk("ovr_set", OVERRUN, 1);
        chk("ovr_ovalid_early", OVALID, 0);
        @(negedge CLK21M);
        chk("ovr_ovalid", OVALID, 1);
        chk("ovr_odata", ODATA, last_out);
        chk("ovr_odata_ch0", ODATA[W-1:0], 300);
        exp_ovr = 1'b1;
        idle(5);
        send({16'd300, 16'd600}, 3'd1, 1'b0);
        chk("ovr_sticky", OVERRUN, 1);
        chk("ovr_after", ODATA[W-1:0], 600);

        // Reset mid-frame: no OVALID, clean restart
        @(negedge CLK21M);
        CLKENA = 1'b1; IDATA = {16'd500, 16'd500}; TAPS_LOG2 = 3'd1;
        @(negedge CLK21M);
        CLKENA = 1'b0; RESET = 1'b1;
        model_clear();
        exp_ovr = 1'b0;
        @(negedge CLK21M);
        RESET = 1'b0;
        chk("midrst_busy", BUSY, 0);
        chk("midrst_odata", ODATA, 0);
        idle(4);
        send({16'd10, 16'd10}, 3'd1, 1'b0);
        chk("midrst_next_ch0", ODATA[W-1:0], 5);
        chk("midrst_next_ch1", ODATA[2*W-1:W], 5);

        // Randomized frames against the reference model
        k = 3'd2;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 5) == 0) k = 3'($urandom);
            d = (C*W)'($urandom);
            send(d, k, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        idle(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
